monopulse_seq: RTL and testbench

Multi-channel successor to the single-pair monopulse divider. Accepts a frame of `N_CHANNELS` reference/error sample pairs in one handshake and time-multiplexes one iterative divider across the channels. For each channel it emits the signed fixed-point ratio error/reference with a channel tag, a divide-by-zero flag, and output back-pressure. It sits between the sample memory reader and the result sink, and replaces the single-pair start/valid loop.

---
 rtl/monopulse_pkg.sv | 39 +++
 rtl/monopulse_seq_divider.sv | 61 ++++++
 rtl/monopulse_seq.sv | 155 +++++++++++++++
 tb/tb_monopulse_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/monopulse_pkg.sv
// Shared types and fixed-point constants for the multi-channel monopulse sequencer.
// Constant helpers return MAX_RES_W-bit values; callers keep the low 2*DATA_SIZE bits.
package monopulse_pkg;

    localparam int MAX_RES_W = 256;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_DIVIDE = 3'd2;
    localparam logic [2:0] ST_FIX    = 3'd3;
    localparam logic [2:0] ST_OUTPUT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD   = ST_LOAD,
        S_DIVIDE = ST_DIVIDE,
        S_FIX    = ST_FIX,
        S_OUTPUT = ST_OUTPUT
    } seq_state_t;

    // Largest positive Q(ds).(ds) value: {0,1...1}
    function automatic logic [MAX_RES_W-1:0] result_max(input int ds);
        return (MAX_RES_W'(1) << (2 * ds - 1)) - MAX_RES_W'(1);
    endfunction

    // Most negative Q(ds).(ds) value: {1,0...0}
    function automatic logic [MAX_RES_W-1:0] result_min(input int ds);
        return MAX_RES_W'(1) << (2 * ds - 1);
    endfunction

    function automatic logic [MAX_RES_W-1:0] sat_pos(input int ds);
        return MAX_RES_W'(1) << ds;
    endfunction

    function automatic logic [MAX_RES_W-1:0] sat_neg(input int ds);
        return -(MAX_RES_W'(1) << ds);
    endfunction

endpackage

// File: rtl/monopulse_seq_divider.sv
// Unsigned restoring divider: 2*W-bit dividend by W-bit divisor, one quotient bit per cycle.
// o_done is high during the cycle in which the final quotient bit is written.
module seq_divider #(
    parameter int W = 64
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [2*W-1:0]   i_dividend,
    input  logic [W-1:0]     i_divisor,
    output logic [2*W-1:0]   o_quotient,
    output logic             o_done
);

    localparam int CW = $clog2(2 * W);

    logic [W:0]     rem;
    logic [2*W-1:0] quo;
    logic [W-1:0]   dsr;
    logic [CW-1:0]  cnt;
    logic           busy;
    logic [W:0]     rem_sh;
    logic           fits;

    // The dividend shifts out of the quotient register as quotient bits shift in.
    assign rem_sh = {rem[W-1:0], quo[2*W-1]};
    assign fits   = (rem_sh >= {1'b0, dsr});

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rem  <= '0;
            quo  <= '0;
            dsr  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (i_start) begin
            rem  <= '0;
            quo  <= i_dividend;
            dsr  <= i_divisor;
            cnt  <= CW'(2 * W - 1);
            busy <= 1'b1;
        end else if (busy) begin
            if (fits) begin
                rem <= rem_sh - {1'b0, dsr};
                quo <= {quo[2*W-2:0], 1'b1};
            end else begin
                rem <= rem_sh;
                quo <= {quo[2*W-2:0], 1'b0};
            end
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign o_quotient = quo;
    assign o_done     = busy && (cnt == '0);

endmodule

// File: rtl/monopulse_seq.sv
// Frame-based monopulse ratio sequencer sharing one restoring divider across channels.
// Define MONOPULSE_SEQ_SAT_EN to clamp results (including divide-by-zero) to +/-1.0.
//
// state  | meaning
// IDLE   | waiting for a frame, o_frame_ready high
// LOAD   | select channel, start divider or flag divide-by-zero
// DIVIDE | divider running, 2*DATA_SIZE cycles
// FIX    | apply sign / zero-divisor / clamp, register result
// OUTPUT | o_valid held until i_ready, then next channel or IDLE
module monopulse_seq
    import monopulse_pkg::*;
#(
    parameter int DATA_SIZE  = 64,
    parameter int N_CHANNELS = 4,
    parameter int CH_W       = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_frame_valid,
    output logic                             o_frame_ready,
    input  logic [N_CHANNELS*DATA_SIZE-1:0]  i_reference,
    input  logic [N_CHANNELS*DATA_SIZE-1:0]  i_error,
    output logic [2*DATA_SIZE-1:0]           o_result,
    output logic [CH_W-1:0]                  o_channel,
    output logic                             o_div_zero,
    output logic                             o_last,
    output logic                             o_valid,
    input  logic                             i_ready
);

    localparam int RW = 2 * DATA_SIZE;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CHANNELS - 1);

`ifdef MONOPULSE_SEQ_SAT_EN
    localparam logic [MAX_RES_W-1:0] SAT_POS_W = sat_pos(DATA_SIZE);
    localparam logic [MAX_RES_W-1:0] SAT_NEG_W = sat_neg(DATA_SIZE);
    localparam logic [RW-1:0]        SAT_POS   = SAT_POS_W[RW-1:0];
    localparam logic [RW-1:0]        SAT_NEG   = SAT_NEG_W[RW-1:0];
`else
    localparam logic [MAX_RES_W-1:0] RES_MAX_W = result_max(DATA_SIZE);
    localparam logic [MAX_RES_W-1:0] RES_MIN_W = result_min(DATA_SIZE);
    localparam logic [RW-1:0]        RES_MAX   = RES_MAX_W[RW-1:0];
    localparam logic [RW-1:0]        RES_MIN   = RES_MIN_W[RW-1:0];
`endif

    seq_state_t state, state_nx;

    logic [N_CHANNELS*DATA_SIZE-1:0] ref_q;
    logic [N_CHANNELS*DATA_SIZE-1:0] err_q;
    logic [CH_W-1:0]                 ch;
    logic                            sign_q;
    logic                            dz_q;

    logic [DATA_SIZE-1:0] cur_ref;
    logic [DATA_SIZE-1:0] cur_err;
    logic [DATA_SIZE-1:0] err_abs;
    logic                 ref_zero;
    logic                 accept;
    logic                 div_start;
    logic                 div_done;
    logic [RW-1:0]        quo;
    logic [RW-1:0]        mag;
    logic [RW-1:0]        fix_result;

    assign cur_ref   = ref_q[int'(ch) * DATA_SIZE +: DATA_SIZE];
    assign cur_err   = err_q[int'(ch) * DATA_SIZE +: DATA_SIZE];
    assign err_abs   = cur_err[DATA_SIZE-1] ? -cur_err : cur_err;
    assign ref_zero  = (cur_ref == '0);
    assign accept    = i_frame_valid && o_frame_ready;
    assign div_start = (state == S_LOAD) && !ref_zero;

    seq_divider #(.W(DATA_SIZE)) u_div (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_start    (div_start),
        .i_dividend ({err_abs, {DATA_SIZE{1'b0}}}),
        .i_divisor  (cur_ref),
        .o_quotient (quo),
        .o_done     (div_done)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept) state_nx = S_LOAD;
            S_LOAD:   state_nx = ref_zero ? S_FIX : S_DIVIDE;
            S_DIVIDE: if (div_done) state_nx = S_FIX;
            S_FIX:    state_nx = S_OUTPUT;
            S_OUTPUT: if (i_ready) state_nx = (ch == LAST_CH) ? S_IDLE : S_LOAD;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Quotient magnitude is below 2^(RW-1), so negation cannot overflow.
    always_comb begin
        mag        = quo;
        fix_result = '0;
`ifdef MONOPULSE_SEQ_SAT_EN
        if (quo > SAT_POS) mag = SAT_POS;
        if (dz_q) fix_result = sign_q ? SAT_NEG : SAT_POS;
        else      fix_result = sign_q ? -mag : mag;
`else
        if (dz_q) fix_result = sign_q ? RES_MIN : RES_MAX;
        else      fix_result = sign_q ? -mag : mag;
`endif
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state         <= S_IDLE;
            o_frame_ready <= 1'b0;
            ref_q         <= '0;
            err_q         <= '0;
            ch            <= '0;
            sign_q        <= 1'b0;
            dz_q          <= 1'b0;
            o_result      <= '0;
            o_channel     <= '0;
            o_div_zero    <= 1'b0;
            o_last        <= 1'b0;
            o_valid       <= 1'b0;
        end else begin
            state         <= state_nx;
            o_frame_ready <= (state_nx == S_IDLE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ref_q <= i_reference;
                        err_q <= i_error;
                        ch    <= '0;
                    end
                end
                S_LOAD: begin
                    sign_q <= cur_err[DATA_SIZE-1];
                    dz_q   <= ref_zero;
                end
                S_FIX: begin
                    o_result   <= fix_result;
                    o_channel  <= ch;
                    o_div_zero <= dz_q;
                    o_last     <= (ch == LAST_CH);
                    o_valid    <= 1'b1;
                end
                S_OUTPUT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        ch      <= ch + CH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_monopulse_seq.sv
// Directed bench for monopulse_seq at DATA_SIZE=16, N_CHANNELS=4.
// Expected values follow MONOPULSE_SEQ_SAT_EN when it is defined for the build.
module tb_monopulse_seq;

    localparam int DS = 16;
    localparam int NC = 4;

    logic          i_clock;
    logic          i_reset;
    logic          i_frame_valid;
    logic          o_frame_ready;
    logic [NC*DS-1:0] i_reference;
    logic [NC*DS-1:0] i_error;
    logic [2*DS-1:0]  o_result;
    logic [1:0]       o_channel;
    logic             o_div_zero;
    logic             o_last;
    logic             o_valid;
    logic             i_ready;

    int passed = 0;
    int total  = 0;

`ifdef MONOPULSE_SEQ_SAT_EN
    localparam logic [31:0] EXP_A2 = 32'h0001_0000;
    localparam logic [31:0] EXP_A3 = 32'h0001_0000;
    localparam logic [31:0] EXP_C3 = 32'hFFFF_0000;
`else
    localparam logic [31:0] EXP_A2 = 32'h7FFF_FFFF;
    localparam logic [31:0] EXP_A3 = 32'h0007_0000;
    localparam logic [31:0] EXP_C3 = 32'h8000_0000;
`endif

    localparam logic [63:0] REF_A = {16'h1000, 16'h0000, 16'h1000, 16'h1000};
    localparam logic [63:0] ERR_A = {16'h7000, 16'h0005, 16'hF800, 16'h0800};
    localparam logic [63:0] REF_C = {16'h0000, 16'hFFFF, 16'h0003, 16'h2000};
    localparam logic [63:0] ERR_C = {16'h8000, 16'h8000, 16'h0001, 16'hFC00};

    monopulse_seq #(.DATA_SIZE(DS), .N_CHANNELS(NC)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_frame_valid (i_frame_valid),
        .o_frame_ready (o_frame_ready),
        .i_reference   (i_reference),
        .i_error       (i_error),
        .o_result      (o_result),
        .o_channel     (o_channel),
        .o_div_zero    (o_div_zero),
        .o_last        (o_last),
        .o_valid       (o_valid),
        .i_ready       (i_ready)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send_frame(input string tag, input logic [63:0] refs, input logic [63:0] errs);
        @(negedge i_clock);
        check({tag, ".ready_before"}, 64'(o_frame_ready), 64'(1));
        i_reference   = refs;
        i_error       = errs;
        i_frame_valid = 1'b1;
        @(posedge i_clock);
        #1;
        i_frame_valid = 1'b0;
        i_reference   = {$urandom, $urandom};
        i_error       = {$urandom, $urandom};
        check({tag, ".ready_after_accept"}, 64'(o_frame_ready), 64'(0));
    endtask

    task automatic take(input string tag, input logic [31:0] er, input logic [1:0] ec,
                        input logic edz, input logic el, input int elat, input int stall);
        int n;
        logic stable;
        n = 0;
        do begin
            @(posedge i_clock);
            #1;
            n++;
        end while (o_valid !== 1'b1 && n < 200);
        check({tag, ".latency"}, 64'(n), 64'(elat));
        check({tag, ".result"}, 64'(o_result), 64'(er));
        check({tag, ".channel"}, 64'(o_channel), 64'(ec));
        check({tag, ".div_zero"}, 64'(o_div_zero), 64'(edz));
        check({tag, ".last"}, 64'(o_last), 64'(el));
        check({tag, ".frame_ready"}, 64'(o_frame_ready), 64'(0));
        if (stall > 0) begin
            stable = 1'b1;
            for (int i = 0; i < stall; i++) begin
                if (i == 3) begin
                    i_frame_valid = 1'b1;
                    i_reference   = {$urandom, $urandom};
                    i_error       = {$urandom, $urandom};
                end else begin
                    i_frame_valid = 1'b0;
                end
                @(posedge i_clock);
                #1;
                if (o_valid !== 1'b1 || o_result !== er || o_channel !== ec ||
                    o_frame_ready !== 1'b0)
                    stable = 1'b0;
            end
            i_frame_valid = 1'b0;
            check({tag, ".stall_stable"}, 64'(stable), 64'(1));
        end
        i_ready = 1'b1;
        @(posedge i_clock);
        #1;
        i_ready = 1'b0;
        check({tag, ".valid_after"}, 64'(o_valid), 64'(0));
        check({tag, ".ready_after"}, 64'(o_frame_ready), 64'(el));
    endtask

    initial begin
        int n;
        i_reset       = 1'b0;
        i_frame_valid = 1'b0;
        i_ready       = 1'b0;
        i_reference   = '0;
        i_error       = '0;

        #3;
        check("rst.valid", 64'(o_valid), 64'(0));
        check("rst.frame_ready", 64'(o_frame_ready), 64'(0));
        check("rst.result", 64'(o_result), 64'(0));
        check("rst.channel", 64'(o_channel), 64'(0));
        check("rst.last", 64'(o_last), 64'(0));
        check("rst.div_zero", 64'(o_div_zero), 64'(0));

        @(negedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b1;
        @(posedge i_clock);
        #1;
        check("rel.frame_ready", 64'(o_frame_ready), 64'(1));

        // Frame A: basic ratios, negative, zero divisor, large quotient; ch1 stalls
        send_frame("A", REF_A, ERR_A);
        take("A0", 32'h0000_8000, 2'd0, 1'b0, 1'b0, 34, 0);
        take("A1", 32'hFFFF_8000, 2'd1, 1'b0, 1'b0, 34, 10);
        take("A2", EXP_A2,        2'd2, 1'b1, 1'b0, 2,  0);
        take("A3", EXP_A3,        2'd3, 1'b0, 1'b1, 34, 0);

        // Frame B: reset mid-DIVIDE
        send_frame("B", REF_A, ERR_A);
        repeat (10) @(posedge i_clock);
        #2;
        i_reset = 1'b0;
        #1;
        check("B.rst_valid", 64'(o_valid), 64'(0));
        check("B.rst_frame_ready", 64'(o_frame_ready), 64'(0));
        @(negedge i_clock);
        i_reset = 1'b1;
        @(posedge i_clock);
        #1;
        check("B.rel_frame_ready", 64'(o_frame_ready), 64'(1));

        // Frame C: inexact quotient, full-scale negative error, negative zero divisor
        send_frame("C", REF_C, ERR_C);
        take("C0", 32'hFFFF_E000, 2'd0, 1'b0, 1'b0, 34, 0);
        take("C1", 32'h0000_5555, 2'd1, 1'b0, 1'b0, 34, 0);
        take("C2", 32'hFFFF_8000, 2'd2, 1'b0, 1'b0, 34, 0);
        take("C3", EXP_C3,        2'd3, 1'b1, 1'b1, 2,  0);

        // Frame D: reset while a result is being presented
        send_frame("D", REF_A, ERR_A);
        n = 0;
        while (o_valid !== 1'b1 && n < 200) begin
            @(posedge i_clock);
            #1;
            n++;
        end
        check("D.valid_seen", 64'(o_valid), 64'(1));
        #2;
        i_reset = 1'b0;
        #1;
        check("D.rst_valid", 64'(o_valid), 64'(0));
        check("D.rst_result", 64'(o_result), 64'(0));
        @(negedge i_clock);
        i_reset = 1'b1;
        @(posedge i_clock);
        #1;
        check("D.rel_frame_ready", 64'(o_frame_ready), 64'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
